// File: rtl/awg_burst_sequencer.sv
// awg_burst_sequencer: runs N NCO periods per trigger then mutes the DAC; AWG_BURST_AUTOREPEAT_EN adds gap-timed auto-repeat
module awg_burst_sequencer #(
    parameter int PHASE_W = 32,
    parameter int CYC_W   = 16,
    parameter int GAP_W   = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               trigger,
    input  logic [CYC_W-1:0]   burst_cycles,
    input  logic [GAP_W-1:0]   gap_clks,
    input  logic [PHASE_W-1:0] phase_acc,
    output logic               nco_run,
    output logic               nco_clear,
    output logic               dac_mute,
    output logic               busy,
    output logic               done,
    output logic [CYC_W-1:0]   cycle_count
);
    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
`ifdef AWG_BURST_AUTOREPEAT_EN
        RUN,
        GAP
`else
        RUN
`endif
    } state_t;
    state_t           state_q;
    logic [CYC_W-1:0] n_lat_q, n_new, count_d;
    logic             msb_q, wrap, last;
`ifdef AWG_BURST_AUTOREPEAT_EN
    logic [GAP_W-1:0] gap_q, g_lat_q;
`endif
    logic             unused_ok;
    assign unused_ok = ^{gap_clks, phase_acc[PHASE_W-2:0]};
    assign wrap      = msb_q & ~phase_acc[PHASE_W-1];
    assign n_new     = (burst_cycles == '0) ? CYC_W'(1) : burst_cycles;
    assign count_d   = cycle_count + 1'b1;
    assign last      = wrap && (count_d == n_lat_q);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            nco_run     <= 1'b0;
            nco_clear   <= 1'b0;
            dac_mute    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            cycle_count <= '0;
            n_lat_q     <= CYC_W'(1);
            msb_q       <= 1'b0;
`ifdef AWG_BURST_AUTOREPEAT_EN
            gap_q       <= '0;
            g_lat_q     <= '0;
`endif
        end else begin
            msb_q     <= phase_acc[PHASE_W-1];
            nco_clear <= 1'b0;
            done      <= 1'b0;
            if (!enable) begin
                state_q  <= IDLE;
                nco_run  <= 1'b1;
                dac_mute <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        nco_run  <= 1'b0;
                        dac_mute <= 1'b1;
                        busy     <= 1'b0;
                        if (trigger) begin
                            state_q     <= CLEAR;
                            n_lat_q     <= n_new;
                            cycle_count <= '0;
`ifdef AWG_BURST_AUTOREPEAT_EN
                            g_lat_q     <= gap_clks;
`endif
                        end
                    end
                    CLEAR: begin
                        // msb_q forced low so the zeroed accumulator cannot look like a wrap
                        nco_clear   <= 1'b1;
                        nco_run     <= 1'b0;
                        dac_mute    <= 1'b1;
                        busy        <= 1'b1;
                        msb_q       <= 1'b0;
                        cycle_count <= '0;
                        state_q     <= RUN;
                    end
                    RUN: begin
                        busy     <= 1'b1;
                        nco_run  <= 1'b1;
                        dac_mute <= 1'b0;
                        if (wrap) cycle_count <= count_d;
                        if (last) begin
                            done     <= 1'b1;
                            nco_run  <= 1'b0;
                            dac_mute <= 1'b1;
`ifdef AWG_BURST_AUTOREPEAT_EN
                            if (g_lat_q == '0) begin
                                state_q <= CLEAR;
                                n_lat_q <= n_new;
                                g_lat_q <= gap_clks;
                            end else begin
                                state_q <= GAP;
                                gap_q   <= g_lat_q - 1'b1;
                            end
`else
                            busy     <= 1'b0;
                            state_q  <= IDLE;
`endif
                        end
                    end
`ifdef AWG_BURST_AUTOREPEAT_EN
                    GAP: begin
                        nco_run  <= 1'b0;
                        dac_mute <= 1'b1;
                        busy     <= 1'b1;
                        if (gap_q == '0) begin
                            state_q <= CLEAR;
                            n_lat_q <= n_new;
                            g_lat_q <= gap_clks;
                        end else begin
                            gap_q <= gap_q - 1'b1;
                        end
                    end
`endif
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_awg_burst_sequencer.sv
// tb_awg_burst_sequencer: random bursts against a period-counting NCO model with a done-event scoreboard
module tb_awg_burst_sequencer;
    localparam int PHASE_W = 32;
    localparam int CYC_W   = 16;
    localparam int GAP_W   = 24;
    logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1, trigger = 1'b0;
    logic [CYC_W-1:0]   burst_cycles = '0;
    logic [GAP_W-1:0]   gap_clks = '0;
    logic [PHASE_W-1:0] phase_acc = '0;
    logic nco_run, nco_clear, dac_mute, busy, done;
    logic [CYC_W-1:0] cycle_count;
    typedef struct {
        int n;
        int p;
        int clr0;
    } exp_t;
    exp_t q[$];
    exp_t e_m;
    int checks = 0, errors = 0;
    int cnt = 0, per = 16, run_cnt = 0, clear_cnt = 0, wraps = 0, done_seen = 0;
    int cyc = 0, t_done = 0, gap_meas = -1;

    always #5 clk = ~clk;

    awg_burst_sequencer #(.PHASE_W(PHASE_W), .CYC_W(CYC_W), .GAP_W(GAP_W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .trigger(trigger),
        .burst_cycles(burst_cycles), .gap_clks(gap_clks), .phase_acc(phase_acc),
        .nco_run(nco_run), .nco_clear(nco_clear), .dac_mute(dac_mute),
        .busy(busy), .done(done), .cycle_count(cycle_count)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: NCO model (period of `per` clocks, MSB set in the upper half) plus done scoreboard
    always @(negedge clk) begin
        cyc++;
        if (rst_n && done === 1'b1) begin
            done_seen++;
            t_done = cyc;
            chk("done_pending", q.size() > 0, 1);
            if (q.size() > 0) begin
                e_m = q.pop_front();
                chk("done_count", cycle_count, e_m.n);
                chk("done_run_clocks", run_cnt, e_m.n * e_m.p);
                chk("done_clears", clear_cnt - e_m.clr0, 1);
                chk("done_run_off", nco_run, 0);
                chk("done_mute", dac_mute, 1);
            end
        end
        if (nco_clear === 1'b1) begin
            gap_meas = cyc - t_done;
            clear_cnt++;
            cnt = 0;
            run_cnt = 0;
        end else if (nco_run === 1'b1) begin
            cnt = (cnt + 1) % per;
            run_cnt++;
            if (cnt == 0) wraps++;
        end
        phase_acc = {(cnt >= per / 2), 31'(cnt)};
    end

    task automatic fire(int n, int p);
        exp_t e;
        @(negedge clk);
        per = p;
        burst_cycles = CYC_W'(n);
        e.n = (n == 0) ? 1 : n;
        e.p = p;
        e.clr0 = clear_cnt;
        q.push_back(e);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        chk("clear_t0", nco_clear, 0);
        @(negedge clk);
        chk("clear_t1", nco_clear, 1);
        chk("run_t1", nco_run, 0);
        @(negedge clk);
        chk("clear_t2", nco_clear, 0);
        chk("run_t2", nco_run, 1);
        chk("mute_t2", dac_mute, 0);
        chk("busy_t2", busy, 1);
    endtask

    task automatic wait_done(int bound);
        int ds;
        ds = done_seen;
        for (int i = 0; i < bound && done_seen == ds; i++) begin
            @(negedge clk);
            #1;
        end
        chk("done_timeout", done_seen != ds, 1);
    endtask

    task automatic wait_wraps(int target, int bound);
        for (int i = 0; i < bound && wraps < target; i++) begin
            @(negedge clk);
            #1;
        end
        chk("wrap_timeout", wraps >= target, 1);
    endtask

    task automatic burst(int n, int p, bit noise);
        int nn;
        nn = (n == 0) ? 1 : n;
        gap_clks = GAP_W'($urandom_range(0, 5));
        fire(n, p);
        if (noise) begin
            repeat (p / 2) @(negedge clk);
            trigger = 1'b1;
            burst_cycles = CYC_W'($urandom_range(1, 9));
            gap_clks = GAP_W'($urandom_range(0, 5));
            @(negedge clk);
            trigger = 1'b0;
        end
        wait_done(nn * p + 20);
`ifdef AWG_BURST_AUTOREPEAT_EN
        enable = 1'b0;
`endif
        repeat (3) @(negedge clk);
`ifndef AWG_BURST_AUTOREPEAT_EN
        chk("post_busy", busy, 0);
        chk("post_mute", dac_mute, 1);
        chk("post_run", nco_run, 0);
        chk("post_count", cycle_count, nn);
`endif
        enable = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, c0;
        exp_t tmp;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_run", nco_run, 0);
        chk("rst_mute", dac_mute, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", cycle_count, 0);
        chk("rst_done", done, 0);
        chk("rst_clear", nco_clear, 0);
        rst_n = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            trigger = 1'b1;
            @(negedge clk);
            trigger = 1'b0;
            repeat (5) @(negedge clk);
            chk("pass_run", nco_run, 1);
            chk("pass_mute", dac_mute, 0);
            chk("pass_busy", busy, 0);
        end
        enable = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_run", nco_run, 0);
        chk("idle_mute", dac_mute, 1);
        burst(3, 100, 1'b0);
        burst(0, 12, 1'b0);
        for (int i = 0; i < 8; i++) burst($urandom_range(0, 5), $urandom_range(8, 30), 1'b1);
        // Abort after two periods of a five-period burst, with a retrigger attempt in between
        gap_clks = '0;
        fire(5, 20);
        w0 = wraps;
        wait_wraps(w0 + 1, 100);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        wait_wraps(w0 + 2, 100);
        repeat (3) @(negedge clk);
        tmp = q.pop_back();
        enable = 1'b0;
        @(negedge clk);
        chk("abort_run", nco_run, 1);
        chk("abort_mute", dac_mute, 0);
        chk("abort_busy", busy, 0);
        chk("abort_count", cycle_count, 2);
        repeat (150) @(negedge clk);
        chk("abort_count_held", cycle_count, 2);
        // Trigger coinciding with enable falling
        enable = 1'b1;
        repeat (2) @(negedge clk);
        trigger = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        trigger = 1'b0;
        chk("same_busy", busy, 0);
        chk("same_run", nco_run, 1);
        @(negedge clk);
        chk("same_clear", nco_clear, 0);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("same_idle_busy", busy, 0);
        // Two-period bursts with a 50-clock gap
        gap_clks = GAP_W'(50);
        c0 = clear_cnt;
        fire(2, 16);
`ifdef AWG_BURST_AUTOREPEAT_EN
        wait_done(60);
        tmp.n = 2;
        tmp.p = 16;
        tmp.clr0 = clear_cnt;
        q.push_back(tmp);
        wait_done(2 * 16 + 50 + 20);
        chk("gap_len", gap_meas, 51);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        repeat (2) @(negedge clk);
`else
        wait_done(60);
        repeat (200) @(negedge clk);
        chk("single_busy", busy, 0);
        chk("single_count", cycle_count, 2);
        chk("single_clears", clear_cnt - c0, 1);
`endif
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
